// File: rtl/comparador_filtrado.sv
// comparador_filtrado: registered signed/unsigned comparator with stability filter,
// one-hot LED decode and saturating commit counters.
module comparador_filtrado #(
    parameter int WIDTH   = 4,
    parameter int ESTABLE = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             valido,
    input  logic             modo_signo,
    input  logic             borrar,
    output logic [3:0]       leds,
    output logic             cambio,
    output logic [CNT_W-1:0] cuenta_a,
    output logic [CNT_W-1:0] cuenta_b
);
    localparam int CW = $clog2(ESTABLE + 1);
    // NADA marks "nothing committed", so raw never matches it.
    typedef enum logic [1:0] {NADA, IGUAL, AMAYOR, BMAYOR} res_t;
    typedef enum logic [1:0] {VACIO, CONFIRMA, FIJO} est_t;
    logic [WIDTH-1:0] r_a, r_b, w_ax, w_bx;
    logic             r_s, r_v, r_cambio;
    est_t             r_estado;
    res_t             r_cand, r_conf, w_raw, w_cval;
    logic [CW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_cnta, r_cntb;
    logic             w_nuevo, w_sube, w_aborta, w_commit;
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        w_ax = r_a;
        w_bx = r_b;
        w_ax[WIDTH-1] = r_a[WIDTH-1] ^ r_s;
        w_bx[WIDTH-1] = r_b[WIDTH-1] ^ r_s;
        w_raw = w_ax > w_bx ? AMAYOR : w_ax < w_bx ? BMAYOR : IGUAL;
        w_nuevo = r_v && (r_estado == VACIO
                  || (r_estado == CONFIRMA && w_raw != r_cand && w_raw != r_conf)
                  || (r_estado == FIJO && w_raw != r_conf));
        w_sube = r_v && r_estado == CONFIRMA && w_raw == r_cand;
        w_aborta = r_v && r_estado == CONFIRMA && w_raw != r_cand && w_raw == r_conf;
        w_commit = (w_nuevo && ESTABLE == 1) || (w_sube && (r_cnt + 1'b1) == CW'(ESTABLE));
        w_cval = w_nuevo ? w_raw : r_cand;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= 1'b0;
            r_v      <= 1'b0;
            r_estado <= VACIO;
            r_cand   <= NADA;
            r_conf   <= NADA;
            r_cnt    <= '0;
            r_cambio <= 1'b0;
            r_cnta   <= '0;
            r_cntb   <= '0;
        end else begin
            r_v      <= valido;
            r_cambio <= w_commit;
            if (valido) begin
                r_a <= A;
                r_b <= B;
                r_s <= modo_signo;
            end
            if (w_nuevo) begin
                r_cand <= w_raw;
                r_cnt  <= CW'(1);
            end
            if (w_sube)
                r_cnt <= r_cnt + 1'b1;
            if (w_aborta) begin
                r_cnt    <= '0;
                r_estado <= FIJO;
            end
            if (w_commit) begin
                r_conf   <= w_cval;
                r_estado <= FIJO;
            end else if (w_nuevo || w_sube)
                r_estado <= CONFIRMA;
            if (borrar) begin
                r_cnta <= '0;
                r_cntb <= '0;
            end else if (w_commit) begin
                if (w_cval == AMAYOR && !(&r_cnta))
                    r_cnta <= r_cnta + 1'b1;
                if (w_cval == BMAYOR && !(&r_cntb))
                    r_cntb <= r_cntb + 1'b1;
            end
        end
    end
    assign leds     = {r_estado == CONFIRMA, r_conf == IGUAL, r_conf == BMAYOR, r_conf == AMAYOR};
    assign cambio   = r_cambio;
    assign cuenta_a = r_cnta;
    assign cuenta_b = r_cntb;
endmodule

// File: doc/comparador_filtrado.md
# comparador_filtrado

Registered, parametrised magnitude comparator with a built-in result decoder and a stability filter. It captures operand pairs A/B on a qualified sample strobe and classifies each pair as A>B, B>A or A=B, unsigned or two's-complement. A classification is committed only after it has held for ESTABLE consecutive valid samples. The committed result drives one-hot LEDs, and saturating counters track how many times each "greater" result has been committed. It sits between the switch/operand inputs and the LED bank, in place of the combinational comparator-plus-decoder pair.

## Interface
- WIDTH, 4: operand width in bits (≥1)
- ESTABLE, 3: consecutive identical valid samples required to commit a result (≥1)
- CNT_W, 8: width of the commit counters (≥1)

- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- valido  input  1  sample strobe; A, B and modo_signo are captured when high
- modo_signo  input  1  0 = unsigned compare, 1 = two's-complement compare
- borrar  input  1  synchronous clear of both counters
- leds  output  4  [0] A>B, [1] B>A, [2] A=B (one-hot committed result), [3] confirming
- cambio  output  1  one-cycle pulse after each commit
- cuenta_a  output  CNT_W  number of commits into A>B, saturating
- cuenta_b  output  CNT_W  number of commits into B>A, saturating

## Operation
- **Stage 1 (capture):**
  - On an edge with valido=1: a_r<=A, b_r<=B, s_r<=modo_signo, v_r<=1.
  - Otherwise v_r<=0, and a_r/b_r/s_r hold.
- **Raw result:** combinational on a_r/b_r/s_r.
  - Codes: IGUAL, AMAYOR, BMAYOR.
  - With s_r=1, the MSB is the sign bit.
- **Stage 2 (FSM):** advances only on edges where v_r=1. Registers: estado, candidato, cnt_est (width ≥ clog2(ESTABLE+1)), confirmado.
- **VACIO** (after reset, nothing committed):
  - Take candidato=raw, cnt_est=1.
  - If ESTABLE=1: commit and go to FIJO. Else go to CONFIRMA.
- **CONFIRMA:**
  - raw==candidato: cnt_est+1. When this reaches ESTABLE, commit and go to FIJO.
  - raw==confirmado, with a committed result present: abort to FIJO, cnt_est=0. This is not a commit.
  - Any other raw: candidato=raw, cnt_est=1 (commit immediately if ESTABLE=1).
- **FIJO:**
  - raw==confirmado: stay.
  - Otherwise: treat exactly as the CONFIRMA "any other raw" case.
- **Commit:**
  - confirmado<=candidato and cambio<=1 for the next cycle.
  - Committing AMAYOR increments cuenta_a; committing BMAYOR increments cuenta_b.
  - Committing IGUAL leaves both counters unchanged.
- **Counters:**
  - Saturate at 2^CNT_W−1.
  - borrar=1 clears both counters and overrides a same-edge increment.
  - borrar does not affect the FSM or leds.
- **leds[2:0]:** one-hot of confirmado; 000 while in VACIO.
- **leds[3]:** 1 while estado=CONFIRMA.
- **Reset (rst_n=0, at any time, including mid-confirmation):**
  - Asynchronous reset to estado=VACIO, all registers 0.
  - leds=0000, cambio=0, cuenta_a=cuenta_b=0.

## Timing
- Sample k is captured at edge k and processed by the FSM at edge k+1.
- With back-to-back valid samples from edge 1, the first commit is at edge ESTABLE+1.
  - leds are valid after that edge.
  - cambio is high from edge ESTABLE+1 to edge ESTABLE+2.
- Idle cycles (valido=0) neither advance nor reset cnt_est.
- leds, cambio and the counters are registered outputs; there are no combinational paths from the inputs to the outputs.
- Counters update on the same edge as the commit.
- Throughput: one sample per cycle.

## Test plan
- **Basic commit:** WIDTH=4, ESTABLE=3. Reset, then A=9, B=3, valido=1 every cycle.
  - leds=1000 after edges 2–3.
  - leds=0001 after edge 4, with cambio high for one cycle.
  - cuenta_a=1, cuenta_b=0.
- **Glitch rejection:** committed A>B, then one sample A=2, B=5, then A=9, B=3 resumes.
  - leds[3] pulses for one cycle and leds[2:0] stay 001.
  - No cambio; counters unchanged.
- **Signed mode:** A=4'hF, B=4'h1, held 3 samples.
  - modo_signo=1 → leds=0010.
  - Reset, then the same with modo_signo=0 → leds=0001.
  - A=B=4'h6 → leds=0100 and counters unchanged.
- **Strobe gaps:** valido pattern 1,0,0,1,0,1 with A=7, B=7.
  - Commit to 0100 occurs only on the edge after the third valid sample.
  - Idle cycles do not alter cnt_est.
- **Saturation and clear:** CNT_W=2, ESTABLE=1, alternating A>B/B>A samples for 10 cycles.
  - cuenta_a and cuenta_b stick at 3.
  - borrar asserted on an edge that commits A>B → both counters read 0 after that edge.
- **Reset mid-confirmation:** assert rst_n=0 between edges while leds[3]=1.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the first commit again requires ESTABLE valid samples.
